// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box table, bit permutation, controller states, legal key sizes.
package present_pkg;

    localparam int KEY_W_80  = 80;
    localparam int KEY_W_128 = 128;

    localparam logic [3:0] SBOX_TABLE [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit i moves to (16*i) mod 63; bit 63 is a fixed point.
    function automatic logic [63:0] player(input logic [63:0] s);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 63; i++) begin
            p[(16 * i) % 63] = s[i];
        end
        p[63] = s[63];
        return p;
    endfunction

endpackage

// File: rtl/present_sbox4.sv
// 4-bit PRESENT S-box, purely combinational.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    assign y_o = SBOX_TABLE[x_i];

endmodule

// File: rtl/present_cipher_core.sv
// Iterative PRESENT encryption core: one full round per clock, 80- or 128-bit key.
module present_cipher_core
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 31
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [63:0]          plaintext,
    input  logic [KEY_WIDTH-1:0] key,
    output logic [63:0]          ciphertext,
    output logic                 valid,
    output logic                 busy
);

    if (KEY_WIDTH != KEY_W_80 && KEY_WIDTH != KEY_W_128) begin : g_bad_key_width
        $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_cipher_core: ROUNDS must be in 1..31");
    end

    localparam int         KW       = KEY_WIDTH;
    localparam int         CNT_LSB  = (KW == KEY_W_128) ? 62 : 15;
    localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

    state_e         fsm_q, fsm_d;
    logic [63:0]    state_q, state_d;
    logic [KW-1:0]  key_q, key_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [63:0]    ct_q, ct_d;

    logic [63:0]    sbox_in, sbox_out, round_state;
    logic [KW-1:0]  key_rot, key_next;
    logic [3:0]     ks_out_hi, ks_out_lo;

    assign sbox_in = state_q ^ key_q[KW-1 -: 64];

    for (genvar n = 0; n < 16; n++) begin : g_data_sbox
        present_sbox4 u_sbox (
            .x_i (sbox_in[4*n +: 4]),
            .y_o (sbox_out[4*n +: 4])
        );
    end

    assign round_state = player(sbox_out);

    // Key schedule: rotate left by 61, substitute top nibble(s), mix in round counter.
    assign key_rot = {key_q[KW-62:0], key_q[KW-1:KW-61]};

    present_sbox4 u_ks_hi (
        .x_i (key_rot[KW-1 -: 4]),
        .y_o (ks_out_hi)
    );

    if (KW == KEY_W_128) begin : g_ks128
        present_sbox4 u_ks_lo (
            .x_i (key_rot[KW-5 -: 4]),
            .y_o (ks_out_lo)
        );
    end else begin : g_ks80
        assign ks_out_lo = key_rot[KW-5 -: 4];
    end

    always_comb begin
        key_next               = key_rot;
        key_next[KW-1 -: 4]    = ks_out_hi;
        key_next[KW-5 -: 4]    = ks_out_lo;
        key_next[CNT_LSB +: 5] = key_rot[CNT_LSB +: 5] ^ cnt_q;
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        ct_d    = ct_q;
        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d   = RUN;
                    state_d = plaintext;
                    key_d   = key;
                    cnt_d   = 5'd1;
                end
            end
            RUN: begin
                state_d = round_state;
                key_d   = key_next;
                // Final whitening is folded into the last round so DONE presents a registered result.
                if (cnt_q == LAST_CNT) begin
                    fsm_d = DONE;
                    ct_d  = round_state ^ key_next[KW-1 -: 64];
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            ct_q    <= ct_d;
        end
    end

    assign ready      = (fsm_q == IDLE);
    assign busy       = (fsm_q == RUN) || (fsm_q == DONE);
    assign valid      = (fsm_q == DONE);
    assign ciphertext = ct_q;

endmodule
